// File: rtl/escalonador_pkg.sv
// Shared defaults and FSM state encoding for the round-robin datapath scheduler.
package escalonador_pkg;

  localparam int unsigned N_DEF       = 4;
  localparam int unsigned W_DEF       = 16;
  localparam int unsigned TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    StOcioso  = 2'd0,
    StDispara = 2'd1,
    StEspera  = 2'd2,
    StEntrega = 2'd3
  } estado_t;

endpackage

// File: rtl/escalonador_datapath_if.sv
// Requester bus plus datapath-controller handshake for the scheduler.
interface escalonador_datapath_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 16
) ();

  logic [N-1:0]   req;
  logic [N*W-1:0] x_in;
  logic [N-1:0]   ack;
  logic [W-1:0]   res_out;
  logic           erro;
  logic           busy;
  logic           dp_inicio;
  logic [W-1:0]   dp_x;
  logic           dp_pronto;
  logic [W-1:0]   dp_res;

  modport slave (
    input  req, x_in, dp_pronto, dp_res,
    output ack, res_out, erro, busy, dp_inicio, dp_x
  );

  modport master (
    output req, x_in, dp_pronto, dp_res,
    input  ack, res_out, erro, busy, dp_inicio, dp_x
  );

endinterface

// File: rtl/escalonador_datapath_arbitro_rr.sv
// Combinational round-robin pick: first unmasked requester at or after ptr, wrapping mod N.
module arbitro_rr #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [N-1:0]  elig;
  logic [IW-1:0] j;

  assign elig = req & ~mask;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IW'((32'(ptr) + k) % N);
      if (!valid && elig[j]) begin
        valid    = 1'b1;
        idx      = j;
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/escalonador_datapath.sv
// Round-robin scheduler sharing one multi-cycle datapath among N requesters, with timeout abort.
module escalonador_datapath
  import escalonador_pkg::*;
#(
  parameter int unsigned N       = N_DEF,
  parameter int unsigned W       = W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input logic                  clk,
  input logic                  rst,
  escalonador_datapath_if.slave bus
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  estado_t       st_q;
  logic [IW-1:0] ptr_q, g_q;
  logic [N-1:0]  gnt_q;
  logic [CW-1:0] cnt_q;
  logic          erro_q, pos_ack_q;
  logic [N-1:0]  ack_q;
  logic          busy_q, dp_inicio_q;
  logic [W-1:0]  dp_x_q, res_q;

  logic [N-1:0]  mask, grant;
  logic [IW-1:0] idx;
  logic          valid;

  // The requester just acknowledged sits out exactly one arbitration cycle.
  assign mask = pos_ack_q ? gnt_q : '0;

  arbitro_rr #(.N(N)) u_arbitro (
    .req   (bus.req),
    .mask  (mask),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (idx),
    .valid (valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= StOcioso;
      ptr_q       <= '0;
      g_q         <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      erro_q      <= 1'b0;
      pos_ack_q   <= 1'b0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      dp_inicio_q <= 1'b0;
      dp_x_q      <= '0;
      res_q       <= '0;
    end else begin
      ack_q       <= '0;
      dp_inicio_q <= 1'b0;
      pos_ack_q   <= 1'b0;
      unique case (st_q)
        StOcioso: begin
          if (valid) begin
            g_q         <= idx;
            gnt_q       <= grant;
            dp_x_q      <= bus.x_in[32'(idx)*W +: W];
            busy_q      <= 1'b1;
            dp_inicio_q <= 1'b1;
            st_q        <= StDispara;
          end
        end
        StDispara: begin
          cnt_q <= '0;
          st_q  <= StEspera;
        end
        StEspera: begin
          if (bus.dp_pronto) begin
            res_q <= bus.dp_res;
            ack_q <= gnt_q;
            st_q  <= StEntrega;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            cnt_q  <= cnt_q + 1'b1;
            res_q  <= '0;
            erro_q <= 1'b1;
            ack_q  <= gnt_q;
            st_q   <= StEntrega;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StEntrega: begin
          ptr_q     <= (g_q == IW'(N - 1)) ? '0 : g_q + 1'b1;
          erro_q    <= 1'b0;
          busy_q    <= 1'b0;
          pos_ack_q <= 1'b1;
          st_q      <= StOcioso;
        end
        default: st_q <= StOcioso;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.erro      = erro_q;
  assign bus.busy      = busy_q;
  assign bus.dp_inicio = dp_inicio_q;
  assign bus.dp_x      = dp_x_q;
  assign bus.res_out   = res_q;

endmodule

// File: tb/tb_escalonador_datapath.sv
// Directed plus randomized bench for escalonador_datapath; the bench plays requesters and datapath.
module tb_escalonador_datapath;

  localparam int N       = 4;
  localparam int W       = 16;
  localparam int TIMEOUT = 15;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  // Reference model state: round-robin pointer and the last served requester.
  int ptr_m  = 0;
  int last_m = -1;
  bit fresh_m = 0;

  escalonador_datapath_if #(.N(N), .W(W)) bus ();

  escalonador_datapath #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p, input int excl);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_ack"}, bus.ack, 0);
    chk({tag, "_erro"}, bus.erro, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_inicio"}, bus.dp_inicio, 0);
    chk({tag, "_dpx"}, bus.dp_x, 0);
    chk({tag, "_res"}, bus.res_out, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.dp_pronto = 1'b0;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0;
    ptr_m = 0;
    last_m = -1;
    fresh_m = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.dp_pronto = 1'($urandom_range(0, 1));
      bus.dp_res = 16'($urandom);
      @(negedge clk);
      chk("idle_busy", bus.busy, 0);
      chk("idle_ack", bus.ack, 0);
    end
    bus.dp_pronto = 1'b0;
    fresh_m = 0;
  endtask

  // One full transaction; delay >= TIMEOUT means the datapath never answers.
  task automatic serve(input int delay, input logic [W-1:0] data, input bit drop, input bit keep,
                       output int got);
    int exp_idx, exp_wait, waitc, esp;
    logic [W-1:0] exp_x, exp_res;
    bit tout;
    got = -1;
    exp_wait = 1;
    exp_idx = pick(bus.req, ptr_m, fresh_m ? last_m : -1);
    if (exp_idx < 0) begin
      exp_idx = pick(bus.req, ptr_m, -1);
      exp_wait = 2;
    end
    if (exp_idx < 0) exp_idx = 0;
    exp_x = bus.x_in[exp_idx*W +: W];
    waitc = 0;
    do begin
      @(negedge clk);
      waitc++;
    end while (!bus.dp_inicio && waitc < 20);
    chk("dispatch_latency", waitc, exp_wait);
    fresh_m = 0;
    if (!bus.dp_inicio) return;
    chk("dp_x", bus.dp_x, exp_x);
    bus.dp_pronto = 1'($urandom_range(0, 1));
    bus.dp_res = 16'($urandom);
    tout = (delay >= TIMEOUT);
    exp_res = tout ? '0 : data;
    esp = 0;
    for (int k = 0; k < TIMEOUT + 5; k++) begin
      @(negedge clk);
      if (bus.ack != 0) break;
      esp++;
      chk("inicio_once", bus.dp_inicio, 0);
      chk("dp_x_stable", bus.dp_x, exp_x);
      bus.x_in = {$urandom, $urandom};
      if (drop && k == 0) bus.req[exp_idx] = 1'b0;
      bus.dp_pronto = (k == delay);
      bus.dp_res = (k == delay) ? data : 16'($urandom);
    end
    bus.dp_pronto = 1'b0;
    chk("ack", bus.ack, 64'(1) << exp_idx);
    chk("erro", bus.erro, tout);
    chk("res_out", bus.res_out, exp_res);
    chk("espera_cycles", esp, tout ? TIMEOUT : delay + 1);
    chk("busy_entrega", bus.busy, 1);
    for (int i = 0; i < N; i++) if (bus.ack[i]) got = i;
    ptr_m = (exp_idx + 1) % N;
    last_m = exp_idx;
    fresh_m = 1;
    if (!keep) bus.req[exp_idx] = 1'b0;
    @(negedge clk);
    chk("ack_pulse", bus.ack, 0);
    chk("erro_pulse", bus.erro, 0);
    chk("busy_idle", bus.busy, 0);
    chk("res_hold", bus.res_out, exp_res);
  endtask

  initial begin
    int got, n;
    bus.req = '0;
    bus.x_in = '0;
    bus.dp_pronto = 1'b0;
    bus.dp_res = '0;
    do_reset();

    // Single request, datapath answers 7 cycles after dp_inicio.
    bus.x_in = 64'h5;
    bus.req = 4'b0001;
    serve(6, 16'h0031, 0, 0, got);
    chk("single_idx", got, 0);

    // Full contention from ptr=0: served in index order.
    do_reset();
    bus.x_in = 64'h4444_3333_2222_1111;
    bus.req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      serve(i + 1, 16'(16'hA0 + i), 0, 0, got);
      chk("contention_order", got, i);
    end
    chk("ptr_wrap", ptr_m, 0);

    // Fairness wrap: move ptr to 3, then 3 beats 0.
    bus.req = 4'b0100;
    serve(2, 16'h0BEE, 0, 0, got);
    chk("ptr3_setup", got, 2);
    bus.req = 4'b1001;
    serve(1, 16'h1234, 0, 0, got);
    chk("wrap_first", got, 3);
    serve(3, 16'h5678, 0, 0, got);
    chk("wrap_second", got, 0);

    // Timeout.
    bus.req = 4'b0100;
    serve(TIMEOUT + 3, 16'hFFFF, 0, 0, got);
    chk("timeout_idx", got, 2);

    // Re-request: 0 stays high but 1 is served next; then lone 0 waits one cycle.
    do_reset();
    bus.req = 4'b0011;
    serve(0, 16'h0010, 0, 1, got);
    chk("rereq_first", got, 0);
    serve(0, 16'h0011, 0, 0, got);
    chk("rereq_second", got, 1);
    bus.req = 4'b0001;
    serve(1, 16'h0012, 0, 1, got);
    serve(1, 16'h0013, 0, 0, got);
    chk("rereq_self", got, 0);

    // Reset mid-ESPERA aborts silently.
    bus.req = 4'b0001;
    n = 0;
    while (!bus.dp_inicio && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk("abort_dispatch", bus.dp_inicio, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    @(negedge clk);
    chk_quiet("abort");
    rst = 1'b0;
    ptr_m = 0;
    last_m = -1;
    fresh_m = 0;
    idle(2);
    bus.x_in = 64'h77;
    bus.req = 4'b0001;
    serve(4, 16'h0042, 0, 0, got);
    chk("after_abort_idx", got, 0);

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      int d;
      bus.req = 4'($urandom_range(1, 15));
      bus.x_in = {$urandom, $urandom};
      d = ($urandom_range(0, 5) == 0) ? TIMEOUT + int'($urandom_range(0, 2))
                                      : int'($urandom_range(0, 8));
      serve(d, 16'($urandom), $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), got);
      if ($urandom_range(0, 3) == 0) begin
        bus.req = '0;
        idle(2);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
